lfsr_prbs_checker: RTL and testbench



---
 rtl/lfsr_prbs_checker_if.sv | 22 ++
 rtl/lfsr_prbs_checker.sv | 132 +++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_prbs_checker_if.sv
// Serial bit-stream link between an LFSR/PRBS source and lfsr_prbs_checker.
// master drives the bit strobe and counter clear; slave returns lock and error status.
interface lfsr_prbs_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output en, din, clr_cnt,
    input  locked, err, err_count
  );

  modport slave (
    input  en, din, clr_cnt,
    output locked, err, err_count
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising checker for the Fibonacci LFSR generator: fill, hunt for lock, then count bit errors.
// Optional macro LFSR_CHK_RESYNC_EN: RESYNC_ERRS consecutive locked-mode errors force a return to FILL.
module lfsr_prbs_checker #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'('hB8),
  parameter int unsigned     LOCK_COUNT  = 16,
  parameter int unsigned     CNT_W       = 16,
  parameter int unsigned     RESYNC_ERRS = 4
) (
  input logic                clk,
  input logic                reset,
  lfsr_prbs_checker_if.slave bus
);

  localparam int unsigned FILL_W  = $clog2(WIDTH) + 1;
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT) + 1;
`ifdef LFSR_CHK_RESYNC_EN
  localparam int unsigned RUN_W   = $clog2(RESYNC_ERRS) + 1;
`endif

  if (WIDTH < 3 || LOCK_COUNT < 1 || RESYNC_ERRS < 1) begin : g_bad_params
    $error("lfsr_prbs_checker: WIDTH >= 3, LOCK_COUNT >= 1 and RESYNC_ERRS >= 1 required");
  end

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SYNC,
    ST_LOCKED
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   r;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic               locked_q;
  logic               err_q;
  logic [CNT_W-1:0]   err_count_q;
`ifdef LFSR_CHK_RESYNC_EN
  logic [RUN_W-1:0]   err_run;
`endif

  logic pred_c;
  logic r_nz_c;

  // Next bit the generator would emit given the last WIDTH bits seen
  assign pred_c = ^(r & TAPS);
  assign r_nz_c = |r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FILL;
      r           <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
`ifdef LFSR_CHK_RESYNC_EN
      err_run     <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        case (state)
          ST_FILL: begin
            r        <= {r[WIDTH-2:0], bus.din};
            fill_cnt <= fill_cnt + FILL_W'(1);
            if (fill_cnt == FILL_W'(WIDTH - 1)) begin
              state     <= ST_SYNC;
              match_cnt <= '0;
            end
          end

          ST_SYNC: begin
            r <= {r[WIDTH-2:0], bus.din};
            // All-zero history predicts zeros forever; never count it toward lock
            if (bus.din != pred_c) begin
              match_cnt <= '0;
            end else if (r_nz_c) begin
              match_cnt <= match_cnt + MATCH_W'(1);
              if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                state    <= ST_LOCKED;
                locked_q <= 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
                err_run  <= '0;
`endif
              end
            end
          end

          ST_LOCKED: begin
            // Free-run on the prediction so one bad channel bit yields one error
            r <= {r[WIDTH-2:0], pred_c};
            if (bus.din != pred_c) begin
              err_q <= 1'b1;
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + CNT_W'(1);
              end
`ifdef LFSR_CHK_RESYNC_EN
              if (err_run == RUN_W'(RESYNC_ERRS - 1)) begin
                state     <= ST_FILL;
                fill_cnt  <= '0;
                match_cnt <= '0;
                locked_q  <= 1'b0;
                err_run   <= '0;
              end else begin
                err_run <= err_run + RUN_W'(1);
              end
            end else begin
              err_run <= '0;
`endif
            end
          end

          default: begin
            state <= ST_FILL;
          end
        endcase

        // Clear takes priority over a coincident increment
        if (bus.clr_cnt) begin
          err_count_q <= '0;
        end
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Self-checking bench for lfsr_prbs_checker against a queue-based behavioural model.
// Build with +define+LFSR_CHK_RESYNC_EN to exercise the resync variant.
module tb_lfsr_prbs_checker;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  TP = 8'hB8;
  localparam int unsigned LC = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned RE = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  lfsr_prbs_checker_if #(.CNT_W(CW)) bus ();

  lfsr_prbs_checker #(
    .WIDTH(W), .TAPS(TP), .LOCK_COUNT(LC), .CNT_W(CW), .RESYNC_ERRS(RE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- generator (stimulus source) ----------------
  logic [7:0] gs;

  task automatic gen_bit(output bit o);
    o  = ^(gs & TP);
    gs = {gs[6:0], o};
  endtask

  // ---------------- behavioural reference model ----------------
  // hist[0] is the newest bit; phase: 0 = filling, 1 = hunting, 2 = locked
  bit hist[$];
  int phase, filled, run, bad, errs;
  bit exp_locked, exp_err;

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int i = 0; i < int'(W); i++) if (TP[i]) p ^= hist[i];
    return p;
  endfunction

  function automatic bit model_nonzero();
    foreach (hist[i]) if (hist[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input bit b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(W); i++) hist.push_back(1'b0);
    phase = 0; filled = 0; run = 0; bad = 0; errs = 0;
    exp_locked = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit c);
    bit p, nz;
    p  = model_pred();
    nz = model_nonzero();
    exp_err = 1'b0;
    if (phase == 0) begin
      model_push(d);
      filled++;
      if (filled == int'(W)) begin phase = 1; run = 0; end
    end else if (phase == 1) begin
      model_push(d);
      if (d != p) run = 0;
      else if (nz) run++;
      if (run == int'(LC)) begin phase = 2; bad = 0; end
    end else begin
      model_push(p);
      if (d != p) begin
        exp_err = 1'b1;
        if (errs < CNT_MAX) errs++;
        bad++;
`ifdef LFSR_CHK_RESYNC_EN
        if (bad == int'(RE)) begin phase = 0; filled = 0; run = 0; bad = 0; end
`endif
      end else begin
        bad = 0;
      end
    end
    if (c) errs = 0;
    exp_locked = (phase == 2);
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit e, input bit d, input bit c);
    @(negedge clk);
    reset = 1'b0; bus.en = e; bus.din = d; bus.clr_cnt = c;
    @(posedge clk);
    #1;
    if (e) model_step(d, c);
    else exp_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.en = 1'b1; bus.din = 1'($urandom); bus.clr_cnt = 1'($urandom);
    @(posedge clk);
    #1;
    model_reset();
  endtask

  function automatic logic [CW+1:0] got_vec();
    return {bus.locked, bus.err, bus.err_count};
  endfunction

  function automatic logic [CW+1:0] exp_vec();
    return {exp_locked, exp_err, CW'(errs)};
  endfunction

  // Lock onto a clean stream from seed 1, n bits
  task automatic lock_up(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      cycle(1'b1, b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL lock_up bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (got_vec() !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", got_vec());
    end
  endtask

  task automatic test_clean_lock();
    bit b;
    int first_lock = -1;
    do_reset(); gs = 8'h01;
    for (int i = 0; i < 500; i++) begin
      gen_bit(b);
      cycle(1'b1, b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL clean_stream bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
      if (bus.locked === 1'b1 && first_lock < 0) first_lock = i + 1;
    end
    n_checks++;
    if (first_lock != int'(W + LC)) begin
      n_fail++; $display("FAIL lock_latency: got %0d expected %0d", first_lock, W + LC);
    end
    n_checks++;
    if (bus.err_count !== '0) begin
      n_fail++; $display("FAIL clean_err_count: got %0d expected 0", bus.err_count);
    end
  endtask

  task automatic test_single_error();
    bit b;
    int pulses = 0, err_at = -1;
    do_reset(); gs = 8'h01;
    for (int i = 0; i < 200; i++) begin
      gen_bit(b);
      cycle(1'b1, (i == 100) ? ~b : b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single_error bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
      if (bus.err === 1'b1) begin pulses++; err_at = i; end
    end
    n_checks++;
    if (pulses != 1 || err_at != 100) begin
      n_fail++; $display("FAIL single_error_pulse: got %0d pulses at %0d expected 1 at 100", pulses, err_at);
    end
    n_checks++;
    if (bus.err_count !== CW'(1)) begin
      n_fail++; $display("FAIL single_error_count: got %0d expected 1", bus.err_count);
    end
  endtask

  task automatic test_en_random();
    bit b, e;
    int enabled = 0, lock_at = -1;
    logic [CW+1:0] prev;
    do_reset(); gs = 8'h01;
    for (int cyc = 0; cyc < 600 && enabled < 200; cyc++) begin
      e = 1'($urandom);
      if (e) begin gen_bit(b); enabled++; end
      else b = 1'($urandom);
      prev = got_vec();
      cycle(e, b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL en_random cyc %0d: got %h expected %h", cyc, got_vec(), exp_vec());
      end
      if (!e) begin
        n_checks++;
        if (got_vec() !== {prev[CW+1], 1'b0, prev[CW-1:0]}) begin
          n_fail++; $display("FAIL en_low_hold cyc %0d: got %h expected %h", cyc, got_vec(), {prev[CW+1], 1'b0, prev[CW-1:0]});
        end
      end
      if (bus.locked === 1'b1 && lock_at < 0) lock_at = enabled;
    end
    n_checks++;
    if (lock_at != int'(W + LC)) begin
      n_fail++; $display("FAIL en_random_lock: got %0d enabled bits expected %0d", lock_at, W + LC);
    end
  endtask

  task automatic test_zero_stream();
    bit b;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec() || bus.locked !== 1'b0) begin
        n_fail++; $display("FAIL zero_stream bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
    gs = 8'h01;
    for (int i = 0; i < 60; i++) begin
      gen_bit(b);
      cycle(1'b1, b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL zero_recover bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_resync();
    bit b;
    int pulses = 0;
    do_reset(); gs = 8'h01;
    lock_up(40);
    for (int i = 0; i < int'(RE); i++) begin
      gen_bit(b);
      cycle(1'b1, ~b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL burst bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
      if (bus.err === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != int'(RE) || bus.err_count !== CW'(RE)) begin
      n_fail++; $display("FAIL burst_errors: got %0d pulses count %0d expected %0d", pulses, bus.err_count, RE);
    end
`ifdef LFSR_CHK_RESYNC_EN
    n_checks++;
    if (bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL resync_drop: got locked %b expected 0", bus.locked);
    end
`else
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_hold: got locked %b expected 1", bus.locked);
    end
`endif
    lock_up(int'(W + LC));
    n_checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== CW'(RE)) begin
      n_fail++; $display("FAIL relock: got locked %b count %0d expected 1 and %0d", bus.locked, bus.err_count, RE);
    end
  endtask

  task automatic test_saturation();
    bit b;
    do_reset(); gs = 8'h01;
    lock_up(30);
    for (int i = 0; i < 40; i++) begin
      gen_bit(b);
      cycle(1'b1, (i % 2 == 0) ? ~b : b, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL saturate bit %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.err_count !== CW'(CNT_MAX)) begin
      n_fail++; $display("FAIL saturate_final: got %0d expected %0d", bus.err_count, CNT_MAX);
    end
  endtask

  task automatic test_clr_collision();
    bit b;
    do_reset(); gs = 8'h01;
    lock_up(30);
    gen_bit(b); cycle(1'b1, ~b, 1'b0);
    gen_bit(b); cycle(1'b1, b, 1'b0);
    n_checks++;
    if (bus.err_count !== CW'(1)) begin
      n_fail++; $display("FAIL pre_clr_count: got %0d expected 1", bus.err_count);
    end
    gen_bit(b); cycle(1'b1, ~b, 1'b1);
    n_checks++;
    if (bus.err !== 1'b1 || bus.err_count !== '0 || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL clr_collision: got err %b count %0d expected err 1 count 0", bus.err, bus.err_count);
    end
  endtask

  task automatic test_reset_mid_lock();
    bit b;
    do_reset(); gs = 8'h01;
    lock_up(30);
    gen_bit(b); cycle(1'b1, ~b, 1'b0);
    gen_bit(b); cycle(1'b1, b, 1'b0);
    do_reset();
    n_checks++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_count !== '0) begin
      n_fail++; $display("FAIL reset_mid_lock: got %h expected 0", got_vec());
    end
    gen_bit(b); cycle(1'b1, b, 1'b0);
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL post_reset: got %h expected %h", got_vec(), exp_vec());
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.din = 1'b0; bus.clr_cnt = 1'b0;
    gs = 8'h01;
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_en_random();
    test_zero_stream();
    test_resync();
    test_saturation();
    test_clr_collision();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
